setting_ctrl: RTL and testbench

Central controller for the clock's user-setting path. It turns debounced single-cycle button pulses into the current display mode and the selected edit position. It drives the per-digit blink mask seen by the display driver, and issues one-hot increment strobes to the time and alarm counters. It sits between the button debouncers and the display/counter blocks, and it consumes the blink tick produced by the existing NCO.

---
 rtl/clock_pkg.sv | 20 ++
 rtl/idle_timer.sv | 19 +
 rtl/setting_ctrl.sv | 68 ++++++
 tb/tb_setting_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: mode/position codes and display digit bit-map shared by the clock blocks.
package clock_pkg;
  typedef enum logic [1:0] {
    MODE_CLOCK   = 2'd0,
    MODE_SETTING = 2'd1,
    MODE_ALARM   = 2'd2
  } mode_t;
  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_t;
  localparam logic [5:0] DIGITS_SEC  = 6'b000011;
  localparam logic [5:0] DIGITS_MIN  = 6'b001100;
  localparam logic [5:0] DIGITS_HOUR = 6'b110000;
  localparam logic [5:0] DIGITS_ALL  = 6'b111111;
  function automatic logic [5:0] digits_of(pos_t p);
    return p == POS_HOUR ? DIGITS_HOUR : p == POS_MIN ? DIGITS_MIN : DIGITS_SEC;
  endfunction
endpackage

// File: rtl/idle_timer.sv
// idle_timer: counts seconds of inactivity and pulses expire on the TIMEOUT_SEC-th tick.
module idle_timer #(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic sec_tick,
  output logic expire
);
  logic [7:0] count;
  // expiry is combinational so the owner can leave its mode on the very next edge
  assign expire = enable && !clear && sec_tick && count == 8'(TIMEOUT_SEC - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clear || expire) count <= '0;
    else if (enable && sec_tick) count <= count + 8'd1;
endmodule

// File: rtl/setting_ctrl.sv
// setting_ctrl: button-driven mode/position FSM, blink mask and one-hot increment strobes.
module setting_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw_mode,
  input  logic       i_sw_position,
  input  logic       i_sw_inc,
  input  logic       i_blink_tick,
  input  logic       i_sec_tick,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic [5:0] o_blink_mask,
  output logic [2:0] o_inc_time,
  output logic [2:0] o_inc_alarm
);
  mode_t      mode, mode_n;
  pos_t       position, position_n;
  logic       phase, phase_n;
  logic [2:0] inc_time_n, inc_alarm_n, pos_hot;
  logic       key_mode, key_pos, key_inc, any_key, expire;
  assign key_mode = i_sw_mode;
  assign key_pos  = !i_sw_mode && i_sw_position;
  assign key_inc  = !i_sw_mode && !i_sw_position && i_sw_inc;
  assign any_key  = key_mode || key_pos || key_inc;
  assign pos_hot  = {position == POS_HOUR, position == POS_MIN, position == POS_SEC};
  idle_timer #(.TIMEOUT_SEC(TIMEOUT_SEC)) u_idle (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (any_key || mode == MODE_CLOCK),
    .enable  (mode != MODE_CLOCK),
    .sec_tick(i_sec_tick),
    .expire  (expire)
  );
  always_comb begin
    mode_n = key_mode ? (mode == MODE_CLOCK ? MODE_SETTING :
                         mode == MODE_SETTING ? MODE_ALARM : MODE_CLOCK) :
             expire ? MODE_CLOCK : mode;
    position_n = (key_mode || expire) ? POS_SEC :
                 (key_pos && mode != MODE_CLOCK) ? (position == POS_SEC ? POS_MIN :
                                                    position == POS_MIN ? POS_HOUR : POS_SEC) :
                 position;
    // a pressed key keeps the edited digit lit, overriding a coincident blink tick
    phase_n     = (any_key || expire || mode == MODE_CLOCK) ? 1'b1 : phase ^ i_blink_tick;
    inc_time_n  = (key_inc && mode == MODE_SETTING) ? pos_hot : 3'b000;
    inc_alarm_n = (key_inc && mode == MODE_ALARM) ? pos_hot : 3'b000;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode        <= MODE_CLOCK;
      position    <= POS_SEC;
      phase       <= 1'b1;
      o_inc_time  <= '0;
      o_inc_alarm <= '0;
    end else begin
      mode        <= mode_n;
      position    <= position_n;
      phase       <= phase_n;
      o_inc_time  <= inc_time_n;
      o_inc_alarm <= inc_alarm_n;
    end
  assign o_mode       = mode;
  assign o_position   = position;
  assign o_blink_mask = (mode == MODE_CLOCK || phase) ? DIGITS_ALL : ~digits_of(position);
endmodule

// File: tb/tb_setting_ctrl.sv
// tb_setting_ctrl: directed and random stimulus against a behavioural model of setting_ctrl.
module tb_setting_ctrl;
  localparam int TO = 3;
  logic       clk = 0, rst_n = 0;
  logic       sw_mode = 0, sw_pos = 0, sw_inc = 0, blink = 0, sec = 0;
  logic [1:0] o_mode, o_position;
  logic [5:0] o_blink_mask;
  logic [2:0] o_inc_time, o_inc_alarm;
  int checks = 0, failures = 0;
  int m_mode, m_pos, m_phase, m_idle, m_it, m_ia;

  setting_ctrl #(.TIMEOUT_SEC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .i_sw_mode(sw_mode), .i_sw_position(sw_pos),
    .i_sw_inc(sw_inc), .i_blink_tick(blink), .i_sec_tick(sec),
    .o_mode(o_mode), .o_position(o_position), .o_blink_mask(o_blink_mask),
    .o_inc_time(o_inc_time), .o_inc_alarm(o_inc_alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_phase = 1; m_idle = 0; m_it = 0; m_ia = 0;
  endtask

  function automatic int model_mask();
    if (m_mode == 0 || m_phase == 1) return 63;
    return 63 & ~(3 << (2 * m_pos));
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_mode"}, int'(o_mode), m_mode);
    chk({tag, "_pos"}, int'(o_position), m_pos);
    chk({tag, "_mask"}, int'(o_blink_mask), model_mask());
    chk({tag, "_inct"}, int'(o_inc_time), m_it);
    chk({tag, "_inca"}, int'(o_inc_alarm), m_ia);
  endtask

  task automatic model_step(input bit m, p, i, b, s);
    bit pk, ik, any, ex;
    pk  = !m && p;
    ik  = !m && !p && i;
    any = m || pk || ik;
    ex  = !any && m_mode != 0 && s && (m_idle + 1 == TO);
    m_it = (ik && m_mode == 1) ? (1 << m_pos) : 0;
    m_ia = (ik && m_mode == 2) ? (1 << m_pos) : 0;
    if (any || ex || m_mode == 0) m_idle = 0;
    else if (s) m_idle++;
    m_phase = (any || ex || m_mode == 0) ? 1 : (m_phase ^ int'(b));
    if (m || ex) m_pos = 0;
    else if (pk && m_mode != 0) m_pos = (m_pos + 1) % 3;
    if (m) m_mode = (m_mode + 1) % 3;
    else if (ex) m_mode = 0;
  endtask

  task automatic cycle(input string tag, input bit m, p, i, b, s);
    sw_mode = m; sw_pos = p; sw_inc = i; blink = b; sec = s;
    @(posedge clk);
    model_step(m, p, i, b, s);
    #1;
    sw_mode = 0; sw_pos = 0; sw_inc = 0; blink = 0; sec = 0;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #3 rst_n = 0;
    #1;
    model_reset();
    check_all(tag);
    #3 rst_n = 1;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    chk("reset_mask_3f", int'(o_blink_mask), 6'h3F);
    rst_n = 1;
    cycle("mode1", 1, 0, 0, 0, 0);
    chk("tp_mode1", int'(o_mode), 1);
    chk("tp_mask_3f", int'(o_blink_mask), 6'h3F);
    cycle("blink1", 0, 0, 0, 1, 0);
    chk("tp_mask_3c", int'(o_blink_mask), 6'h3C);
    cycle("pos1", 0, 1, 0, 0, 0);
    chk("tp_pos1", int'(o_position), 1);
    cycle("blink2", 0, 0, 0, 1, 0);
    chk("tp_mask_33", int'(o_blink_mask), 6'h33);
    cycle("pos2", 0, 1, 0, 0, 0);
    chk("tp_pos2", int'(o_position), 2);
    cycle("inc_h", 0, 0, 1, 0, 0);
    chk("tp_inct_100", int'(o_inc_time), 3'b100);
    cycle("inc_h_off", 0, 0, 0, 0, 0);
    chk("tp_inct_one_cycle", int'(o_inc_time), 0);
    cycle("pos3", 0, 1, 0, 0, 0);
    chk("tp_pos_wrap", int'(o_position), 0);
    cycle("mode_inc", 1, 0, 1, 0, 0);
    chk("tp_mode_inc_mode", int'(o_mode), 2);
    chk("tp_mode_inc_nostrobe", int'(o_inc_time | o_inc_alarm), 0);
    cycle("inc_a", 0, 0, 1, 0, 0);
    chk("tp_inca_001", int'(o_inc_alarm), 3'b001);
    cycle("blink3", 0, 0, 0, 1, 0);
    cycle("pos_blink", 0, 1, 0, 1, 0);
    chk("tp_pos_blink_lit", int'(o_blink_mask), 6'h3F);
    cycle("mode_wrap", 1, 0, 0, 0, 0);
    chk("tp_mode_wrap", int'(o_mode), 0);
    cycle("clk_inc", 0, 0, 1, 0, 0);
    chk("tp_clock_inc", int'(o_inc_time | o_inc_alarm), 0);
    cycle("clk_pos", 0, 1, 0, 0, 0);
    chk("tp_clock_pos", int'(o_position), 0);
    // timeout with no keys
    cycle("to_mode", 1, 0, 0, 0, 0);
    cycle("to_pos", 0, 1, 0, 0, 0);
    cycle("to_s1", 0, 0, 0, 0, 1);
    cycle("to_s2", 0, 0, 0, 1, 1);
    chk("tp_to_before", int'(o_mode), 1);
    cycle("to_s3", 0, 0, 0, 0, 1);
    chk("tp_to_mode", int'(o_mode), 0);
    chk("tp_to_pos", int'(o_position), 0);
    // key on the expiry tick wins and clears the counter
    cycle("tk_mode", 1, 0, 0, 0, 0);
    cycle("tk_s1", 0, 0, 0, 0, 1);
    cycle("tk_s2", 0, 0, 0, 0, 1);
    cycle("tk_s3i", 0, 0, 1, 0, 1);
    chk("tp_tk_stay", int'(o_mode), 1);
    chk("tp_tk_strobe", int'(o_inc_time), 3'b001);
    cycle("tk_s4", 0, 0, 0, 0, 1);
    cycle("tk_s5", 0, 0, 0, 0, 1);
    chk("tp_tk_cleared", int'(o_mode), 1);
    cycle("tk_s6", 0, 0, 0, 0, 1);
    chk("tp_tk_expire", int'(o_mode), 0);
    // async reset mid-edit in ALARM with a live strobe
    cycle("ar_m1", 1, 0, 0, 0, 0);
    cycle("ar_m2", 1, 0, 0, 0, 0);
    cycle("ar_p", 0, 1, 0, 0, 0);
    cycle("ar_b", 0, 0, 0, 1, 0);
    cycle("ar_i", 0, 0, 1, 0, 0);
    chk("tp_ar_pre", int'(o_inc_alarm), 3'b010);
    async_reset("areset");
    chk("tp_ar_strobe", int'(o_inc_alarm), 0);
    chk("tp_ar_mask", int'(o_blink_mask), 6'h3F);
    for (int k = 0; k < 3000; k++) begin
      cycle("rnd", $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0);
      if (k % 700 == 350) async_reset("rnd_areset");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
